// File: rtl/and_or_bist.sv
// Self-test driver/checker for a registered 4-input AND-OR block f = (a&b)|(c&d).
// Optional abort-on-first-mismatch behaviour is enabled by defining AND_OR_BIST_STOP_ON_FAIL_EN.
module and_or_bist #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned PASSES  = 1,
    parameter int unsigned ERR_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             f_in,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int unsigned TAIL   = LATENCY - 1;
    localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned DRN_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          vec_q, vec_d;
    logic [PASS_W-1:0]   pcnt_q, pcnt_d;
    logic [DRN_W-1:0]    dcnt_q, dcnt_d;
    logic [3:0]          abcd_q, abcd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [3:0]          ffvec_q, ffvec_d;
    logic                ffv_q, ffv_d;
    // Expected-response delay line: valid, expected f and originating vector per stage.
    logic [LATENCY-1:0]  pv_q, pv_d;
    logic [LATENCY-1:0]  pe_q, pe_d;
    logic [3:0]          pvec_q [LATENCY];
    logic [3:0]          pvec_d [LATENCY];
    logic                mism_c;

    assign {a, b, c, d}     = abcd_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;

    // Next-state, pipeline and scoreboard logic.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        pcnt_d  = pcnt_q;
        dcnt_d  = dcnt_q;
        abcd_d  = abcd_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffvec_d = ffvec_q;
        ffv_d   = ffv_q;
        pv_d    = pv_q;
        pe_d    = pe_q;
        pvec_d  = pvec_q;

        pv_d[0]   = (state_q == DRIVE);
        pe_d[0]   = (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]);
        pvec_d[0] = vec_q;
        for (int i = 1; i < int'(LATENCY); i++) begin
            pv_d[i]   = pv_q[i-1];
            pe_d[i]   = pe_q[i-1];
            pvec_d[i] = pvec_q[i-1];
        end

        mism_c = pv_q[TAIL] && (f_in != pe_q[TAIL]);
        if (mism_c) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + ERR_W'(1);
            end
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = pvec_q[TAIL];
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    vec_d   = 4'd0;
                    pcnt_d  = '0;
                    abcd_d  = 4'd0;
                end
            end
            DRIVE: begin
                vec_d  = vec_q + 4'd1;
                abcd_d = vec_q + 4'd1;
                if (vec_q == 4'hF) begin
                    if (pcnt_q == PASS_W'(PASSES - 1)) begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                        abcd_d  = 4'd0;
                    end else begin
                        pcnt_d = pcnt_q + PASS_W'(1);
                    end
                end
            end
            DRAIN: begin
                abcd_d = 4'd0;
                if (dcnt_q == DRN_W'(LATENCY - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    dcnt_d = dcnt_q + DRN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AND_OR_BIST_STOP_ON_FAIL_EN
        // First mismatch ends the run immediately and discards in-flight vectors.
        if (mism_c && ((state_q == DRIVE) || (state_q == DRAIN))) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            abcd_d  = 4'd0;
            pv_d    = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            pcnt_q  <= '0;
            dcnt_q  <= '0;
            abcd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffvec_q <= '0;
            ffv_q   <= 1'b0;
            pv_q    <= '0;
            pe_q    <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                pvec_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            pcnt_q  <= pcnt_d;
            dcnt_q  <= dcnt_d;
            abcd_q  <= abcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffvec_q <= ffvec_d;
            ffv_q   <= ffv_d;
            pv_q    <= pv_d;
            pe_q    <= pe_d;
            pvec_q  <= pvec_d;
        end
    end

endmodule
